pid_core: RTL and testbench



---
 rtl/pid_core.sv | 206 ++++++++++++++++++++
 tb/tb_pid_core.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_core.sv
`default_nettype none
// ============================================================================
// Module   : pid_core
// Purpose  : Closed-loop PID engine for the BLDC speed loop. For every
//            accepted speed sample it produces one saturated control word.
//            Kp*e, Ki*integ and Kd*d are formed one after another on a
//            single serial shift-add multiplier, so the latency is fixed.
// Options  : PID_CORE_OVERRUN_EN adds a sticky overrun flag that records
//            strobes dropped while busy or before the gains are valid.
// Revision : 1.0 - initial release
// ============================================================================
module pid_core #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_SHIFT = 4,
  parameter int INT_LIMIT  = 8191
) (
  input  logic                  clk_div,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] setpoint,
  input  logic [DATA_WIDTH-1:0] period_speed,
  input  logic                  sample_strobe,
  input  logic                  tuning_done,
  input  logic [7:0]            Kp,
  input  logic [7:0]            Ki,
  input  logic [6:0]            Kd,
  output logic [DATA_WIDTH-1:0] control_out,
  output logic                  out_valid,
  output logic                  busy
`ifdef PID_CORE_OVERRUN_EN
  ,
  output logic                  overrun
`endif
);

  localparam int PW      = DATA_WIDTH + 8;                // signed x unsigned(8) product
  localparam int SAT_MAX = (1 <<< (DATA_WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(1 <<< (DATA_WIDTH - 1));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ERR   = 3'd1,
    MUL_P = 3'd2,
    MUL_I = 3'd3,
    MUL_D = 3'd4,
    SUM   = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [7:0]                   kp_q, ki_q, kd_q;
  logic                         gains_valid;
  logic signed [DATA_WIDTH-1:0] sp_q, pv_q;
  logic signed [DATA_WIDTH-1:0] integ, e_prev, d_q;
  logic signed [PW-1:0]         mcand, prod;
  logic [7:0]                   mplier;
  logic [2:0]                   bit_cnt;
  logic signed [31:0]           sum;

  logic                         accept;
  logic signed [DATA_WIDTH-1:0] e_new, d_new, integ_new, ctl_new;
  logic signed [31:0]           integ_sum;
  logic signed [PW-1:0]         addend, prod_nxt;

  // Clamp a wide signed value into the DATA_WIDTH two's-complement range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [31:0] v);
    if (v > SAT_MAX)
      sat_dw = DATA_WIDTH'(SAT_MAX);
    else if (v < SAT_MIN)
      sat_dw = DATA_WIDTH'(SAT_MIN);
    else
      sat_dw = v[DATA_WIDTH-1:0];
  endfunction

  // Error/integral/derivative terms, one multiplier step and the final scaling.
  always_comb begin
    accept    = (state == IDLE) && !busy && gains_valid && sample_strobe;
    e_new     = sat_dw(32'(sp_q) - 32'(pv_q));
    integ_sum = 32'(integ) + 32'(e_new);
    if (integ_sum > INT_LIMIT)
      integ_new = DATA_WIDTH'(INT_LIMIT);
    else if (integ_sum < -INT_LIMIT)
      integ_new = DATA_WIDTH'(-INT_LIMIT);
    else
      integ_new = integ_sum[DATA_WIDTH-1:0];
    d_new     = sat_dw(32'(e_new) - 32'(e_prev));
    addend    = mplier[0] ? mcand : {PW{1'b0}};
    prod_nxt  = prod + addend;
    ctl_new   = sat_dw(sum >>> FRAC_SHIFT);
  end

  // Sequencing: each multiply phase lasts exactly eight cycles regardless of gain.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ERR;
      ERR:     state_nxt = MUL_P;
      MUL_P:   if (bit_cnt == 3'd7) state_nxt = MUL_I;
      MUL_I:   if (bit_cnt == 3'd7) state_nxt = MUL_D;
      MUL_D:   if (bit_cnt == 3'd7) state_nxt = SUM;
      SUM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_div) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Gains follow the tuner only while idle, so a running computation sees stable gains.
  always_ff @(posedge clk_div) begin
    if (reset) begin
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      gains_valid <= 1'b0;
    end else if ((state == IDLE) && tuning_done) begin
      kp_q        <= Kp;
      ki_q        <= Ki;
      kd_q        <= {1'b0, Kd};
      gains_valid <= 1'b1;
    end
  end

  // Datapath: sample capture, error update, serial multiply-accumulate, output.
  always_ff @(posedge clk_div) begin
    if (reset) begin
      sp_q        <= '0;
      pv_q        <= '0;
      integ       <= '0;
      e_prev      <= '0;
      d_q         <= '0;
      mcand       <= '0;
      prod        <= '0;
      mplier      <= '0;
      bit_cnt     <= '0;
      sum         <= '0;
      control_out <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          // busy is held through the cycle in which out_valid is high
          if (accept) begin
            sp_q <= setpoint;
            pv_q <= period_speed;
            busy <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ERR: begin
          integ   <= integ_new;
          e_prev  <= e_new;
          d_q     <= d_new;
          sum     <= '0;
          prod    <= '0;
          bit_cnt <= '0;
          mcand   <= PW'(e_new);
          mplier  <= kp_q;
        end
        MUL_P, MUL_I, MUL_D: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            // last partial product: fold into the sum and load the next operand pair
            sum  <= sum + 32'(prod_nxt);
            prod <= '0;
            if (state == MUL_P) begin
              mcand  <= PW'(integ);
              mplier <= ki_q;
            end else begin
              mcand  <= PW'(d_q);
              mplier <= kd_q;
            end
          end else begin
            prod   <= prod_nxt;
            mcand  <= mcand <<< 1;
            mplier <= mplier >> 1;
          end
        end
        SUM: begin
          control_out <= ctl_new;
          out_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PID_CORE_OVERRUN_EN
  // Sticky record of any strobe that could not be accepted.
  always_ff @(posedge clk_div) begin
    if (reset)
      overrun <= 1'b0;
    else if (sample_strobe && (busy || !gains_valid))
      overrun <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pid_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_core
// Purpose  : Self-checking bench for pid_core: directed scenarios followed by
//            randomized samples compared against an arithmetic PID model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_core;

  logic        clk_div = 1'b0;
  logic        reset;
  logic [15:0] setpoint, period_speed;
  logic        sample_strobe, tuning_done;
  logic [7:0]  Kp, Ki;
  logic [6:0]  Kd;
  logic [15:0] control_out;
  logic        out_valid, busy;
`ifdef PID_CORE_OVERRUN_EN
  logic        overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_integ, m_eprev, g_kp, g_ki, g_kd;

  pid_core dut (
    .clk_div      (clk_div),
    .reset        (reset),
    .setpoint     (setpoint),
    .period_speed (period_speed),
    .sample_strobe(sample_strobe),
    .tuning_done  (tuning_done),
    .Kp           (Kp),
    .Ki           (Ki),
    .Kd           (Kd),
    .control_out  (control_out),
    .out_valid    (out_valid),
    .busy         (busy)
`ifdef PID_CORE_OVERRUN_EN
    ,
    .overrun      (overrun)
`endif
  );

  // clock
  always #5 clk_div = ~clk_div;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // One PID step computed directly from the control law.
  function automatic int model_step(input int sp, input int pv);
    int e, d;
    longint s;
    e = sat16(longint'(sp) - longint'(pv));
    m_integ = m_integ + e;
    if (m_integ > 8191) m_integ = 8191;
    if (m_integ < -8191) m_integ = -8191;
    d = sat16(longint'(e) - longint'(m_eprev));
    m_eprev = e;
    s = longint'(g_kp) * e + longint'(g_ki) * m_integ + longint'(g_kd) * d;
    return sat16(s >>> 4);
  endfunction

  task automatic model_reset();
    m_integ = 0; m_eprev = 0; g_kp = 0; g_ki = 0; g_kd = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, $signed(control_out), 0);
    check({tag, "_vld"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef PID_CORE_OVERRUN_EN
    check({tag, "_ovr"}, overrun, 0);
`endif
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_reset();
    reset = 1'b1; sample_strobe = 1'b0; tuning_done = 1'b0;
    @(negedge clk_div);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_gains(input int kp, input int ki, input int kd);
    Kp = 8'(kp); Ki = 8'(ki); Kd = 7'(kd);
    tuning_done = 1'b1;
    @(negedge clk_div);
    tuning_done = 1'b0;
    g_kp = kp; g_ki = ki; g_kd = kd;
  endtask

  // Strobe one sample and watch the full 28-cycle window; optional second
  // strobe, mid-run reset, or mid-run retune attempt.
  task automatic run_sample(input string tag, input int sp, input int pv, input int strobe2_at,
                            input int reset_at, input bit retune, output int got);
    int exp;
    bit rt;
    got = 0;
    setpoint = 16'(sp); period_speed = 16'(pv); sample_strobe = 1'b1;
    exp = model_step(sp, pv);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk_div);
      sample_strobe = (k == strobe2_at);
      if (k == strobe2_at) setpoint = 16'(sp + 1234);
      reset = (k == reset_at);
      rt = retune && (k >= 8) && (k <= 12);
      tuning_done = rt;
      Kp = rt ? 8'd99 : 8'(g_kp);
      if (reset_at != 0 && k > reset_at) begin
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_vld"}, out_valid, 0);
        check({tag, "_rst_ctl"}, $signed(control_out), 0);
      end else if (k <= 27) begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_vld"}, out_valid, (k == 27) ? 1 : 0);
      end else begin
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_vld_end"}, out_valid, 0);
      end
      if (reset_at == 0 && k == 27) begin
        check({tag, "_ctl"}, $signed(control_out), exp);
        got = int'($signed(control_out));
      end
    end
    if (reset_at != 0) model_reset();
  endtask

  initial begin
    int got;
    int sp, pv;
    reset = 1'b1; setpoint = '0; period_speed = '0; sample_strobe = 1'b0;
    tuning_done = 1'b0; Kp = '0; Ki = '0; Kd = '0;
    model_reset();
    @(negedge clk_div);
    @(negedge clk_div);
    reset = 1'b0;
    check_reset_outputs("reset");

    // strobe without valid gains is dropped
    setpoint = 16'd1000; period_speed = 16'd900; sample_strobe = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_div);
      sample_strobe = 1'b0;
      check("nogain_busy", busy, 0);
      check("nogain_vld", out_valid, 0);
      check("nogain_ctl", $signed(control_out), 0);
    end
`ifdef PID_CORE_OVERRUN_EN
    check("nogain_ovr", overrun, 1);
`endif

    // proportional only, then back-to-back sample
    set_gains(16, 0, 0);
    run_sample("p1", 1000, 900, 0, 0, 0, got);
    check("p1_const", got, 100);
    run_sample("p2", 900, 1000, 0, 0, 0, got);
    check("p2_const", got, -100);

    // integral only, then integral clamp
    do_reset();
    set_gains(0, 16, 0);
    run_sample("i1", 1000, 900, 0, 0, 0, got); check("i1_const", got, 100);
    run_sample("i2", 1000, 900, 0, 0, 0, got); check("i2_const", got, 200);
    run_sample("i3", 1000, 900, 0, 0, 0, got); check("i3_const", got, 300);
    do_reset();
    set_gains(0, 16, 0);
    run_sample("ic1", 5000, 0, 0, 0, 0, got); check("ic1_const", got, 5000);
    run_sample("ic2", 5000, 0, 0, 0, 0, got); check("ic2_const", got, 8191);

    // derivative only
    do_reset();
    set_gains(0, 0, 16);
    run_sample("d1", 1000, 900, 0, 0, 0, got); check("d1_const", got, 100);
    run_sample("d2", 1000, 900, 0, 0, 0, got); check("d2_const", got, 0);
    run_sample("d3", 900, 950, 0, 0, 0, got);  check("d3_const", got, -150);

    // saturation extremes
    do_reset();
    set_gains(255, 0, 0);
    run_sample("sat_hi", 32767, 0, 0, 0, 0, got);      check("sat_hi_const", got, 32767);
    run_sample("sat_lo", -32768, 32767, 0, 0, 0, got); check("sat_lo_const", got, -32768);

    // strobe while busy, retune attempt while busy, reset mid-run
    do_reset();
    set_gains(16, 0, 0);
`ifdef PID_CORE_OVERRUN_EN
    check("ovr_clear", overrun, 0);
`endif
    run_sample("ovl", 1000, 900, 5, 0, 0, got); check("ovl_const", got, 100);
`ifdef PID_CORE_OVERRUN_EN
    check("ovl_ovr", overrun, 1);
`endif
    run_sample("rtn1", 1000, 800, 0, 0, 1, got); check("rtn1_const", got, 200);
    run_sample("rtn2", 1000, 700, 0, 0, 0, got); check("rtn2_const", got, 300);
    run_sample("mrst", 1000, 900, 0, 12, 0, got);
    check_reset_outputs("mrst_end");

    // randomized samples and gains against the model
    do_reset();
    for (int g = 0; g < 3; g++) begin
      set_gains(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
      for (int s = 0; s < 8; s++) begin
        if ($urandom_range(0, 1) == 1) begin
          sp = int'($urandom_range(0, 65535)) - 32768;
          pv = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          sp = int'($urandom_range(0, 4000)) - 2000;
          pv = int'($urandom_range(0, 4000)) - 2000;
        end
        run_sample("rnd", sp, pv, 0, 0, 0, got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
